cache_mem_responder: RTL and testbench
======================================

Name: cache_mem_responder

Overview:
- Memory-side responder for the data cache's miss and writeback traffic.
- Accepts one word request at a time over a valid/ready handshake:
  - a read, which is a refill for a cache miss;
  - a write, which is a dirty-line writeback.
- Models main-memory latency with a programmable cycle count, then returns a one-cycle response pulse.
- Sits between the cache's miss/writeback port and the backing word array.

Parameters:
- DEPTH_LOG2, 10: log2 of the number of 32-bit words stored. Address bits [DEPTH_LOG2+1:2] index the array.
- LATENCY, 4: cycles from request acceptance to response. Legal range is 1..15.
- INIT_ZERO, 1: when 1, the array is initialised to 0 at time zero. The array is never cleared by reset.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_write  in  1  1 = writeback (store req_wdata), 0 = refill read.
- req_addr  in  32  byte address; bits [1:0] must be 00.
- req_wdata  in  32  write data, used only when req_write=1.
- resp_valid  out  1  one-cycle pulse: the request has completed.
- resp_rdata  out  32  read data, valid when resp_valid=1 on a read.
- resp_err  out  1  qualifies resp_valid: the request was unaligned and was not performed.
- busy  out  1  a request is in flight (state is not IDLE).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Values after reset:
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0.
  - State is IDLE and the latency counter is 0.
- State machine, three states:
  - IDLE: req_ready=1. On req_valid=1, capture write, addr and wdata, load the counter with LATENCY-1, and go to WAIT. If LATENCY=1, go directly to RESP.
  - WAIT: req_ready=0. Decrement the counter each cycle. When the counter reaches 0, go to RESP.
  - RESP: req_ready=0, resp_valid=1 for exactly one cycle, then return to IDLE.
- Latency: a request accepted at edge T produces resp_valid high in the cycle following edge T+LATENCY-1, which is exactly LATENCY cycles after acceptance.
- Throughput: at most one request per LATENCY+1 cycles. A new request can be accepted in the cycle immediately after RESP.
- Capture rule: request fields are sampled only at acceptance. Changes to req_* while busy are ignored. req_valid held high during WAIT/RESP is not accepted until IDLE.
- Reads:
  - resp_rdata equals mem[captured index] in the RESP cycle.
  - resp_rdata holds its value until the next read response.
- Writes:
  - The array is written at the edge that ends RESP.
  - resp_rdata is unchanged on a write.
  - A read of the same address accepted afterwards returns the new data.
- Address handling:
  - Upper bits above DEPTH_LOG2+1 are ignored, so addresses wrap modulo 4*2^DEPTH_LOG2 bytes.
  - If captured addr[1:0] is not 00: no array write, resp_rdata is forced to 0, and resp_err=1 in the RESP cycle. Latency is unchanged.
  - resp_err=0 in every cycle in which resp_valid=0.
- Reset mid-operation:
  - The in-flight request is abandoned: no response, and no write to the array.
  - Array contents are preserved.
  - Next cycle: IDLE with req_ready=1.
- Reset has priority over acceptance in the same cycle: the request is not accepted.

Decomposition:
- Shared package cache_mem_pkg holds:
  - the state enumeration (IDLE, WAIT, RESP), encoded as 2 bits;
  - the default LATENCY and DEPTH_LOG2 constants;
  - the word width constant (32).
  The cache and this responder share the latter two.
- One sub-module, word_ram: a single-port synchronous-write, asynchronous-read 2^DEPTH_LOG2 x 32 array with an optional zero-initialisation.
- The state machine and counter stay in the top module.

Test Plan:
- Read after write, LATENCY=4:
  - Write 0xDEADBEEF to 0x0000_0040: resp_valid pulses 4 cycles after acceptance, with resp_err=0.
  - Then read 0x40: resp_rdata=0xDEADBEEF and resp_valid goes high exactly 4 cycles later.
- Wrap: write 0x1234_5678 to 0x0000_1000. A read of 0x0000_0000 returns 0x1234_5678, since the 1024-word array wraps.
- Unaligned: read at 0x0000_0042 gives resp_valid=1, resp_err=1, resp_rdata=0. A following aligned read of 0x40 is unaffected.
- Busy ignore:
  - Hold req_valid=1 and change req_addr to 0x80 during WAIT.
  - The response uses the originally captured 0x40.
  - The second request is accepted only in the IDLE cycle after RESP.
- Reset mid-flight:
  - Accept a write of 0xA5A5A5A5 to 0x100 and assert reset 2 cycles later.
  - No resp_valid, and req_ready=1 the next cycle.
  - A read of 0x100 returns the old value, 0.
- LATENCY=1 build: back-to-back requests receive responses 1 cycle after acceptance, with acceptance possible every 2 cycles.

Source files
------------

// File: rtl/cache_mem_pkg.sv
// ============================================================================
// Module   : cache_mem_pkg
// Purpose  : Types and constants shared by the data cache and its memory side.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package cache_mem_pkg;

  localparam int unsigned C_WORD_W             = 32;
  localparam int unsigned C_DEFAULT_LATENCY    = 4;
  localparam int unsigned C_DEFAULT_DEPTH_LOG2 = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/cache_mem_responder_word_ram.sv
// ============================================================================
// Module   : word_ram
// Purpose  : Single-port word array, synchronous write, asynchronous read.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module word_ram
  import cache_mem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = C_DEFAULT_DEPTH_LOG2,
  parameter bit          INIT_ZERO  = 1'b1
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [C_WORD_W-1:0]   wdata_i,
  output logic [C_WORD_W-1:0]   rdata_o
);

  localparam int unsigned C_DEPTH = 2 ** DEPTH_LOG2;

  // Contents are only ever set at time zero; reset never touches the array.
  if (INIT_ZERO) begin : g_init_zero
    logic [C_WORD_W-1:0] mem_q [C_DEPTH] = '{default: '0};

    always_ff @(posedge clk) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[addr_i];
  end else begin : g_no_init
    logic [C_WORD_W-1:0] mem_q [C_DEPTH];

    always_ff @(posedge clk) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[addr_i];
  end

endmodule

`default_nettype wire

// File: rtl/cache_mem_responder.sv
// ============================================================================
// Module   : cache_mem_responder
// Purpose  : Fixed-latency memory responder for cache refills and writebacks.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cache_mem_responder
  import cache_mem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = C_DEFAULT_DEPTH_LOG2,
  parameter int unsigned LATENCY    = C_DEFAULT_LATENCY,
  parameter bit          INIT_ZERO  = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [31:0]         req_addr,
  input  logic [C_WORD_W-1:0] req_wdata,
  output logic                resp_valid,
  output logic [C_WORD_W-1:0] resp_rdata,
  output logic                resp_err,
  output logic                busy
);

  localparam logic [3:0] C_CNT_LOAD = 4'(LATENCY - 1);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [1:0]            off_q, off_d;
  logic [C_WORD_W-1:0]   wdata_q, wdata_d;
  logic [C_WORD_W-1:0]   rdata_q, rdata_d;

  logic                  w_aligned;
  logic                  w_ram_we;
  logic [C_WORD_W-1:0]   w_ram_rdata;
  logic                  w_unused;

  // Address bits above the array index are deliberately dropped (wrap).
  assign w_unused  = ^req_addr[31:DEPTH_LOG2+2];
  assign w_aligned = (off_q == 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
      off_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    idx_d   = idx_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          idx_d   = req_addr[DEPTH_LOG2+1:2];
          off_d   = req_addr[1:0];
          wdata_d = req_wdata;
          cnt_d   = C_CNT_LOAD;
          state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Read data is shown combinationally in RESP and then held in rdata_q.
  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    busy       = (state_q != ST_IDLE);
    resp_valid = (state_q == ST_RESP);
    resp_err   = (state_q == ST_RESP) && !w_aligned;
    rdata_d    = rdata_q;
    if ((state_q == ST_RESP) && !write_q) begin
      rdata_d = w_aligned ? w_ram_rdata : '0;
    end
    resp_rdata = rdata_d;
    w_ram_we   = (state_q == ST_RESP) && write_q && w_aligned && !reset;
  end

  word_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .INIT_ZERO  (INIT_ZERO)
  ) u_word_ram (
    .clk     (clk),
    .we_i    (w_ram_we),
    .addr_i  (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (w_ram_rdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_cache_mem_responder.sv
// ============================================================================
// Module   : tb_cache_mem_responder
// Purpose  : Directed bench for the responder at LATENCY=4 and LATENCY=1.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cache_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        rv, rr, rw, resp_valid, err, busy;
  logic [31:0] ra, rwd, rdata;
  logic        rv1, rr1, rw1, resp_valid1, err1, busy1;
  logic [31:0] ra1, rwd1, rdata1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cache_mem_responder #(.DEPTH_LOG2(10), .LATENCY(4), .INIT_ZERO(1'b1)) dut (
    .clk(clk), .reset(reset), .req_valid(rv), .req_ready(rr), .req_write(rw),
    .req_addr(ra), .req_wdata(rwd), .resp_valid(resp_valid), .resp_rdata(rdata),
    .resp_err(err), .busy(busy)
  );

  cache_mem_responder #(.DEPTH_LOG2(10), .LATENCY(1), .INIT_ZERO(1'b1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(rv1), .req_ready(rr1), .req_write(rw1),
    .req_addr(ra1), .req_wdata(rwd1), .resp_valid(resp_valid1), .resp_rdata(rdata1),
    .resp_err(err1), .busy(busy1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One complete transaction on the LATENCY=4 instance; latency is counted
  // in edges from acceptance to the first sample showing resp_valid.
  task automatic xact(input string tag, input logic w, input logic [31:0] a,
                      input logic [31:0] d, output logic [31:0] rd, output logic e);
    int n;
    rv = 1'b1; rw = w; ra = a; rwd = d;
    chk({tag, "_ready"}, 32'(rr), 32'd1);
    tick;
    rv = 1'b0; rw = 1'b0; ra = '0; rwd = '0;
    n = 0;
    while (!resp_valid && n < 20) begin
      tick;
      n++;
    end
    chk({tag, "_lat"}, 32'(n + 1), 32'd4);
    rd = rdata;
    e  = err;
    tick;
    chk({tag, "_idle_ready"}, 32'(rr), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          n;
    int          seen;

    reset = 1'b1;
    rv = 0; rw = 0; ra = 0; rwd = 0;
    rv1 = 0; rw1 = 0; ra1 = 0; rwd1 = 0;
    tick;
    tick;
    chk("rst_ready", 32'(rr), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick;

    // Read after write.
    xact("wr40", 1'b1, 32'h40, 32'hDEADBEEF, rd, e);
    chk("wr40_err", 32'(e), 32'd0);
    xact("rd40", 1'b0, 32'h40, 32'h0, rd, e);
    chk("rd40_data", rd, 32'hDEADBEEF);
    chk("rd40_err", 32'(e), 32'd0);

    // Wrap at 4 KiB; a write leaves resp_rdata untouched.
    xact("wr1000", 1'b1, 32'h1000, 32'h12345678, rd, e);
    chk("wr1000_rdata_hold", rd, 32'hDEADBEEF);
    xact("rd0", 1'b0, 32'h0, 32'h0, rd, e);
    chk("rd0_wrap_data", rd, 32'h12345678);

    // Unaligned access.
    xact("rd42", 1'b0, 32'h42, 32'h0, rd, e);
    chk("rd42_err", 32'(e), 32'd1);
    chk("rd42_data", rd, 32'd0);
    chk("after_err_low", 32'(err), 32'd0);
    xact("rd40b", 1'b0, 32'h40, 32'h0, rd, e);
    chk("rd40b_data", rd, 32'hDEADBEEF);
    chk("rd40b_err", 32'(e), 32'd0);

    // Request fields change while busy; valid held high throughout.
    rv = 1'b1; rw = 1'b0; ra = 32'h40;
    chk("busy_first_ready", 32'(rr), 32'd1);
    tick;
    ra = 32'h80;
    n = 0;
    while (!resp_valid && n < 20) begin
      chk("busy_wait_ready", 32'(rr), 32'd0);
      tick;
      n++;
    end
    chk("busy_lat", 32'(n + 1), 32'd4);
    chk("busy_data", rdata, 32'hDEADBEEF);
    chk("busy_resp_ready", 32'(rr), 32'd0);
    tick;
    chk("busy_idle_ready", 32'(rr), 32'd1);
    chk("busy_idle_busy", 32'(busy), 32'd0);
    tick;
    chk("busy_second_accept", 32'(busy), 32'd1);
    rv = 1'b0; ra = '0;
    n = 0;
    while (!resp_valid && n < 20) begin
      tick;
      n++;
    end
    chk("busy2_lat", 32'(n + 1), 32'd4);
    chk("busy2_data", rdata, 32'd0);
    tick;

    // Reset two cycles into a write, then reset against a pending request.
    rv = 1'b1; rw = 1'b1; ra = 32'h100; rwd = 32'hA5A5A5A5;
    tick;
    rv = 1'b0; rw = 1'b0;
    tick;
    reset = 1'b1;
    tick;
    chk("midrst_ready", 32'(rr), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    rv = 1'b1; rw = 1'b0; ra = 32'h40;
    tick;
    chk("rst_priority_busy", 32'(busy), 32'd0);
    rv = 1'b0; reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (resp_valid) seen++;
    end
    chk("midrst_no_resp", 32'(seen), 32'd0);
    xact("rd100", 1'b0, 32'h100, 32'h0, rd, e);
    chk("rd100_old_data", rd, 32'd0);

    // LATENCY=1 instance: accept, respond next cycle, accept again after.
    rv1 = 1'b1; rw1 = 1'b1; ra1 = 32'h8; rwd1 = 32'hCAFE0001;
    chk("l1_ready0", 32'(rr1), 32'd1);
    tick;
    chk("l1_wr_resp", 32'(resp_valid1), 32'd1);
    chk("l1_wr_ready", 32'(rr1), 32'd0);
    rw1 = 1'b0;
    tick;
    chk("l1_idle_ready", 32'(rr1), 32'd1);
    chk("l1_idle_resp", 32'(resp_valid1), 32'd0);
    tick;
    chk("l1_rd_resp", 32'(resp_valid1), 32'd1);
    chk("l1_rd_data", rdata1, 32'hCAFE0001);
    chk("l1_rd_err", 32'(err1), 32'd0);
    rv1 = 1'b0;
    tick;
    chk("l1_end_resp", 32'(resp_valid1), 32'd0);
    chk("l1_end_ready", 32'(rr1), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
